// File: rtl/shiftout_pkg.sv
// Shared types for the 74HC595-style serial chain driver.
// Engine states are also visible to bench monitors through this package.
package shiftout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/shiftout_tick.sv
// Phase timer: counts CLK_DIV cycles per engine phase.
// o_phase_end marks the last cycle of the current phase.
module shiftout_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_phase_end
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_phase_end = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shiftout_chain.sv
// Serial driver for 74HC595-style chains: one-word holding buffer feeding a
// shift engine that clocks out WIDTH bits and then pulses the storage latch.
module shiftout_chain
  import shiftout_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             clk_out,
  output logic             data_out,
  output logic             latch_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [BW-1:0]    r_bitcnt;
  logic [BW-1:0]    w_bitcnt_next;
  logic             r_clk;
  logic             r_data;
  logic             r_latch;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_done_next;
  logic             w_accept;
  logic             w_phase_end;
  logic             w_shifting;
  logic             w_cur_bit;

  shiftout_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk       (clk_in),
    .i_rst_n     (reset_in),
    .i_restart   (r_state == IDLE),
    .o_phase_end (w_phase_end)
  );

  // Accept and engine load are mutually exclusive: accept needs an empty hold,
  // load needs a full one.
  assign w_accept  = valid_in & ~r_hold_full;
  assign ready_out = ~r_hold_full;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= data_in;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_load        = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) w_load = 1'b1;
      end
      SHIFT_LO: begin
        if (w_phase_end) w_state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (w_phase_end) begin
          w_shift_next  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
          w_bitcnt_next = r_bitcnt - BW'(1);
          w_state_next  = (r_bitcnt == BW'(1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (w_phase_end) begin
          w_done_next = 1'b1;
          if (r_hold_full) w_load = 1'b1;
          else             w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A queued word starts straight from LATCH, skipping IDLE.
    if (w_load) begin
      w_state_next  = SHIFT_LO;
      w_shift_next  = r_hold;
      w_bitcnt_next = BW'(WIDTH);
    end
  end

  assign w_shifting = (w_state_next == SHIFT_LO) || (w_state_next == SHIFT_HI);
  assign w_cur_bit  = MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0];

  // Pin outputs are registered from the next state so they change cleanly on one edge.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_clk    <= 1'b0;
      r_data   <= 1'b0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bitcnt <= w_bitcnt_next;
      r_clk    <= (w_state_next == SHIFT_HI);
      r_data   <= w_shifting & w_cur_bit;
      r_latch  <= (w_state_next == LATCH);
      r_busy   <= (w_state_next != IDLE);
      r_done   <= w_done_next;
    end
  end

  assign clk_out   = r_clk;
  assign data_out  = r_data;
  assign latch_out = r_latch;
  assign busy_out  = r_busy;
  assign done_out  = r_done;

endmodule

// File: doc/shiftout_chain.md
# shiftout_chain

Parametrised serial shift-register driver for 74HC595-style chains: accepts a WIDTH-bit word over a valid/ready handshake, serialises it MSB- or LSB-first on a divided serial clock, then pulses the storage latch. A one-word holding buffer lets the next frame be queued while the current one shifts, so frames run back-to-back. Sits between the display/IO-expander logic and the board pins driving the external chain.

## Interface
- WIDTH, 16, bits per frame (total chain length); >= 1
- CLK_DIV, 2, system cycles per serial-clock half-period and latch pulse length; >= 1
- MSB_FIRST, 1, 1: bit WIDTH-1 shifted first; 0: bit 0 first

- clk_in  in  1  system clock; all logic on rising edge
- reset_in  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  frame word, sampled on accept
- valid_in  in  1  data_in valid
- ready_out  out  1  holding buffer empty; accept = valid_in & ready_out
- clk_out  out  1  serial clock to chain (SRCLK)
- data_out  out  1  serial data to chain (SER)
- latch_out  out  1  storage latch (RCLK)
- busy_out  out  1  engine not IDLE
- done_out  out  1  one-cycle pulse per completed frame

## Operation
- Holding register (hold, hold_full) plus engine shift register; ready_out = !hold_full.
- Accept writes data_in into hold, sets hold_full. No accept while full, so accept and engine consume never coincide on one edge.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: if hold_full, load shift reg from hold, clear hold_full, bit counter = WIDTH, -> SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): clk_out=0, data_out = current bit (MSB or LSB of shift reg per MSB_FIRST) -> SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): clk_out=1, data_out held. On exit shift register by one, decrement counter; counter nonzero -> SHIFT_LO, else -> LATCH.
- LATCH (CLK_DIV cycles): clk_out=0, data_out=0, latch_out=1. On exit: hold_full -> load and SHIFT_LO directly (no IDLE cycle); else -> IDLE.
- done_out high exactly the cycle after LATCH exit.
- Divider counter width $clog2(CLK_DIV+1); bit counter width $clog2(WIDTH+1); no wrap beyond loaded values.
- valid_in while ready_out low: ignored, data_in not sampled; upstream holds.

## Timing
- Reset (asserted, async): state IDLE, hold_full=0, ready_out=1, clk_out=0, data_out=0, latch_out=0, busy_out=0, done_out=0, counters 0. Mid-frame reset aborts frame; no latch pulse, no done_out; queued word discarded.
- All outputs registered except ready_out (direct from hold_full flop).
- Accept at edge t0 -> engine loads at t1 (from IDLE) -> first bit on data_out and busy_out=1 from t1; ready_out=1 again from t1.
- Frame length from load to LATCH exit: (2*WIDTH + 1)*CLK_DIV cycles; done_out follows one cycle later.
- data_out stable for CLK_DIV cycles before each clk_out rise and CLK_DIV cycles after (setup/hold for chain).
- Back-to-back: throughput one frame per (2*WIDTH+1)*CLK_DIV cycles; done_out of frame N coincides with first SHIFT_LO cycle of frame N+1.

## Structure
- Package shiftout_pkg: state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH), shared by this block and its bench monitor.
- Sub-module shiftout_tick: CLK_DIV phase counter with restart input, emits end-of-phase strobe; reused for every state.
- Top holds handshake buffer, shift register, bit counter, FSM.

## Test plan
- WIDTH=16, CLK_DIV=2, MSB_FIRST=1, word 16'hF335 -> bits sampled at clk_out rises 1111001100110101; one latch pulse 2 cycles wide; done_out 67 cycles after load.
- Same, MSB_FIRST=0, word 16'hAA00 -> bits 0000000001010101.
- Two words offered back-to-back (16'h0001 then 16'h8000) -> second accepted while first shifts, ready_out low until second loads, no IDLE cycle between frames, two done_out pulses 66 cycles apart.
- valid_in held with third word while hold full -> not accepted until ready_out rises; data_in changes while ready_out low never appear on data_out.
- reset_in low mid-SHIFT_HI of bit 5 -> all outputs 0 immediately, ready_out=1, no latch_out/done_out; next word after release shifts correctly.
- WIDTH=1, CLK_DIV=1 -> frame of 3 cycles (lo, hi, latch), done_out on cycle 4.
